// File: rtl/pipe_pkg.sv
// Shared pipeline-control types for the RV64I-Zba core.
// Forwarding select encoding and data-memory wait FSM states.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } memst_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // M has the younger result, so it wins over W.
    function automatic fwd_sel_t fwd_sel(
        input logic [4:0] rs,
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w
    );
        if (regwrite_m && rd_m != REG_X0 && rd_m == rs)
            return FWD_M;
        else if (regwrite_w && rd_w != REG_X0 && rd_w == rs)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_fsm.sv
// Fixed wait-state sequencer for data-memory accesses in M.
// Raises memstall for exactly MEM_WAIT cycles per access.
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_access,
    output logic memstall
);

    localparam bit WAIT_EN  = (MEM_WAIT > 0);
    localparam bit ONE_SHOT = (MEM_WAIT == 1);
    localparam int INIT_I   = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_I);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    memst_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             served_q, served_d;
    logic             start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_RUN;
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
        end
    end

    assign start = WAIT_EN && mem_access && !served_q;

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        served_d = served_q;
        unique case (st_q)
            ST_RUN: begin
                if (start) begin
                    if (ONE_SHOT) begin
                        served_d = 1'b1;
                    end else begin
                        st_d  = ST_WAIT;
                        cnt_d = CNT_INIT;
                    end
                end else begin
                    served_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    st_d     = ST_RUN;
                    served_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: st_d = ST_RUN;
        endcase
    end

    always_comb begin
        memstall = (st_q == ST_WAIT) || (st_q == ST_RUN && start);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for every stage
// register and EX-stage operand forwarding selects.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1_D,
    input  logic [4:0] Rs2_D,
    input  logic [4:0] Rs1_E,
    input  logic [4:0] Rs2_E,
    input  logic [4:0] Rd_E,
    input  logic       MemRead_E,
    input  logic       PCSrc_E,
    input  logic       MemAccess_M,
    input  logic       RegWrite_M,
    input  logic [4:0] Rd_M,
    input  logic       RegWrite_W,
    input  logic [4:0] Rd_W,
    output logic       Stall_F,
    output logic       Stall_D,
    output logic       Stall_E,
    output logic       Stall_M,
    output logic       Stall_W,
    output logic       Flush_D,
    output logic       Flush_E,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E
);

    logic memstall;
    logic lu;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT),
        .CNT_W    (CNT_W)
    ) u_mem_wait (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_access (MemAccess_M),
        .memstall   (memstall)
    );

    // Conservative: no check that the D instruction actually reads rs1/rs2.
    assign lu = MemRead_E && Rd_E != REG_X0 &&
                (Rd_E == Rs1_D || Rd_E == Rs2_D);

    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        if (rst_n) begin
            ForwardA_E = fwd_sel(Rs1_E, RegWrite_M, Rd_M,
                                 RegWrite_W, Rd_W);
            ForwardB_E = fwd_sel(Rs2_E, RegWrite_M, Rd_M,
                                 RegWrite_W, Rd_W);
        end
    end

    // Frozen pipe holds E/D, so redirects and load-use wait for release.
    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Stall_W = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        if (!rst_n) begin
            Stall_F = 1'b0;
        end else if (memstall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Stall_W = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (lu) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_WAIT=2 main instance,
// MEM_WAIT=0 instance for the disabled-FSM case).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       MemRead_E, PCSrc_E, MemAccess_M;
    logic       RegWrite_M, RegWrite_W;

    logic       sf, sd, se, sm, sw, fd, fe;
    logic [1:0] fa, fb;
    logic       zf, zd, ze, zm, zw, zfd, zfe;
    logic [1:0] zfa, zfb;

    logic [4:0] stall, stall0;
    logic [1:0] flush, flush0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_WAIT(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E),
        .MemAccess_M(MemAccess_M),
        .RegWrite_M(RegWrite_M), .Rd_M(Rd_M),
        .RegWrite_W(RegWrite_W), .Rd_W(Rd_W),
        .Stall_F(sf), .Stall_D(sd), .Stall_E(se),
        .Stall_M(sm), .Stall_W(sw),
        .Flush_D(fd), .Flush_E(fe),
        .ForwardA_E(fa), .ForwardB_E(fb)
    );

    hazard_ctrl #(.MEM_WAIT(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E),
        .MemAccess_M(MemAccess_M),
        .RegWrite_M(RegWrite_M), .Rd_M(Rd_M),
        .RegWrite_W(RegWrite_W), .Rd_W(Rd_W),
        .Stall_F(zf), .Stall_D(zd), .Stall_E(ze),
        .Stall_M(zm), .Stall_W(zw),
        .Flush_D(zfd), .Flush_E(zfe),
        .ForwardA_E(zfa), .ForwardB_E(zfb)
    );

    assign stall  = {sf, sd, se, sm, sw};
    assign flush  = {fd, fe};
    assign stall0 = {zf, zd, ze, zm, zw};
    assign flush0 = {zfd, zfe};

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
        Rd_E = 0; Rd_M = 0; Rd_W = 0;
        MemRead_E = 0; PCSrc_E = 0; MemAccess_M = 0;
        RegWrite_M = 0; RegWrite_W = 0;
    endtask

    // drive at negedge, look 1 time unit later
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        MemAccess_M = 1; RegWrite_M = 1;
        Rd_M = 5; Rs1_E = 5; PCSrc_E = 1;
        nxt();
        chk("rst_stall", 8'(stall), 8'h00);
        chk("rst_flush", 8'(flush), 8'h0);
        chk("rst_fwda", 8'(fa), 8'h0);

        @(negedge clk);
        clr_in();
        rst_n = 1'b1;
        #1;
        chk("idle_stall", 8'(stall), 8'h00);
        chk("idle_flush", 8'(flush), 8'h0);

        // forwarding
        RegWrite_M = 1; Rd_M = 5; Rs1_E = 5;
        RegWrite_W = 1; Rd_W = 5;
        #1 chk("fwd_m_wins", 8'(fa), 8'h2);
        Rd_M = 0;
        #1 chk("fwd_w", 8'(fa), 8'h1);
        Rs2_E = 0;
        #1 chk("fwd_x0_b", 8'(fb), 8'h0);
        Rs2_E = 5;
        #1 chk("fwd_b_w", 8'(fb), 8'h1);
        Rd_M = 5; RegWrite_W = 0;
        #1 chk("fwd_b_m", 8'(fb), 8'h2);
        RegWrite_M = 0;
        #1 chk("fwd_none", 8'(fb), 8'h0);
        clr_in();

        // load-use
        nxt();
        MemRead_E = 1; Rd_E = 7; Rs2_D = 7;
        #1 chk("lu_stall", 8'(stall), 8'h18);
        chk("lu_flush", 8'(flush), 8'h1);
        Rd_E = 0;
        #1 chk("lu_x0", 8'(stall), 8'h00);
        Rd_E = 7; Rs2_D = 0; Rs1_D = 7;
        #1 chk("lu_rs1", 8'(stall), 8'h18);
        PCSrc_E = 1;
        #1 chk("br_lu_stall", 8'(stall), 8'h00);
        chk("br_lu_flush", 8'(flush), 8'h3);
        clr_in();

        // memory wait, two back-to-back ops
        nxt();
        MemAccess_M = 1;
        #1 chk("mw1_a", 8'(stall), 8'h1f);
        chk("mw0_none", 8'(stall0), 8'h00);
        nxt();
        chk("mw1_b", 8'(stall), 8'h1f);
        chk("mw0_none2", 8'(stall0), 8'h00);
        nxt();
        chk("mw1_rel", 8'(stall), 8'h00);
        nxt();
        chk("mw2_a", 8'(stall), 8'h1f);
        nxt();
        chk("mw2_b", 8'(stall), 8'h1f);
        nxt();
        chk("mw2_rel", 8'(stall), 8'h00);
        clr_in();

        // redirect deferred during memstall
        nxt();
        MemAccess_M = 1; PCSrc_E = 1;
        MemRead_E = 1; Rd_E = 3; Rs1_D = 3;
        #1 chk("df_stall1", 8'(stall), 8'h1f);
        chk("df_flush1", 8'(flush), 8'h0);
        chk("df0_flush", 8'(flush0), 8'h3);
        nxt();
        chk("df_stall2", 8'(stall), 8'h1f);
        chk("df_flush2", 8'(flush), 8'h0);
        nxt();
        chk("df_rel_stall", 8'(stall), 8'h00);
        chk("df_rel_flush", 8'(flush), 8'h3);
        clr_in();

        // reset in WAIT
        nxt();
        MemAccess_M = 1;
        #1 chk("rw_run", 8'(stall), 8'h1f);
        nxt();
        chk("rw_wait", 8'(stall), 8'h1f);
        rst_n = 1'b0;
        #1 chk("rw_async", 8'(stall), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rw_restall", 8'(stall), 8'h1f);
        nxt();
        chk("rw_wait2", 8'(stall), 8'h1f);
        nxt();
        chk("rw_rel", 8'(stall), 8'h00);
        clr_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
